tick_period_monitor: RTL and testbench
======================================

TICK_PERIOD_MONITOR -- requirements
Module: tick_period_monitor

Interface
REQ-001 SHALL have parameter EXPECTED_HALF, default 32'd50000000, meaning nominal tick half-period in clk cycles.
REQ-002 SHALL have parameter TOLERANCE, default 32'd1000, meaning maximum allowed |measured - EXPECTED_HALF| in clk cycles.
REQ-003 SHALL have parameter LOCK_COUNT, default 4, meaning consecutive in-spec half-periods needed to declare lock.
REQ-004 SHALL have parameter TIMEOUT_HALF, default 2*EXPECTED_HALF, meaning cycles without an edge before timeout.
REQ-005 clk  input  1  single clock, rising edge.
REQ-006 rst_n  input  1  reset, synchronous, active-low.
REQ-007 tick  input  1  toggling square wave from a tick source, not assumed synchronous to clk.
REQ-008 edge_pulse  output  1  one-cycle pulse per detected tick edge (either polarity).
REQ-009 half_period  output  33  last completed half-period measurement, in clk cycles.
REQ-010 meas_valid  output  1  one-cycle strobe when half_period updates.
REQ-011 in_spec  output  1  last measurement within EXPECTED_HALF +/- TOLERANCE.
REQ-012 locked  output  1  LOCK_COUNT consecutive in-spec measurements seen, no violation since.
REQ-013 timeout  output  1  no tick edge for TIMEOUT_HALF cycles.
REQ-014 err_count  output  16  number of out-of-spec measurements since reset, saturating.

Function
REQ-015 tick SHALL pass through a 2-flop synchronizer plus one history flop; an edge is sync_q != hist_q.
REQ-016 edge_pulse SHALL assert exactly 3 clk cycles after a tick transition that meets setup, for one cycle.
REQ-017 A 33-bit cycle counter SHALL increment every cycle, reload to 1 on edge_pulse, and saturate at all-ones.
REQ-018 On edge_pulse in MEASURE or LOCKED, half_period SHALL load the counter value and meas_valid SHALL pulse on the next cycle.
REQ-019 in_spec SHALL be computed from the captured value with 34-bit unsigned comparison (EXPECTED_HALF-TOLERANCE <= hp <= EXPECTED_HALF+TOLERANCE), lower bound clamped at 0.
REQ-020 States: IDLE, MEASURE, LOCKED, TIMEOUT.
REQ-021 IDLE -> MEASURE on first edge_pulse; no measurement captured from that edge.
REQ-022 MEASURE -> LOCKED when in-spec run counter reaches LOCK_COUNT; out-of-spec measurement clears the run counter.
REQ-023 LOCKED -> MEASURE on any out-of-spec measurement; run counter cleared.
REQ-024 MEASURE or LOCKED -> TIMEOUT when counter reaches TIMEOUT_HALF without an edge; locked and in_spec clear that cycle.
REQ-025 TIMEOUT -> MEASURE on next edge_pulse, counter reloads, no measurement captured from that edge; timeout clears.
REQ-026 IDLE SHALL never enter TIMEOUT; timeout asserts only after at least one edge.
REQ-027 locked SHALL be 1 exactly when state is LOCKED.
REQ-028 err_count SHALL increment on each out-of-spec measurement and hold at 16'hFFFF.
REQ-029 Edge and timeout threshold on the same cycle: edge wins, no timeout.

Reset
REQ-030 While rst_n is low at a clk edge: state IDLE, all counters 0, synchronizer and history flops 0, all outputs 0.
REQ-031 Reset mid-measurement SHALL discard the partial count; first edge after release is treated as IDLE->MEASURE.

Structure
REQ-032 State encoding and the 33-bit count width constant SHALL live in a shared package with the tick generator constants.
REQ-033 The synchronizer plus edge detector SHALL be one sub-module, tick_edge_detect.
REQ-034 All logic SHALL be clocked on clk; no derived clocks.

Verification
REQ-035 EXPECTED_HALF=10, TOLERANCE=1, LOCK_COUNT=4; tick toggles every 10 clk -> half_period=10, in_spec=1, locked=1 after 5th edge.
REQ-036 Locked, then one half-period of 13 -> in_spec=0, locked=0, err_count=1, relock after 4 more good halves.
REQ-037 Tick stops after lock, TIMEOUT_HALF=20 -> timeout=1 at count 20, locked=0; next edge -> timeout=0, no meas_valid.
REQ-038 Half-periods of 9 and 11 -> in_spec=1; 8 and 12 -> in_spec=0.
REQ-039 rst_n low for 1 cycle mid-measurement -> all outputs 0, next edge gives no meas_valid, following edge gives correct half_period.
REQ-040 Force err_count to 16'hFFFE path with repeated bad halves -> saturates at 16'hFFFF.

Source files
------------

// File: rtl/tick_period_monitor_pkg.sv
// Shared types and constants for the tick period monitor: FSM encoding,
// counter widths, nominal tick-source figures and the tolerance window check.
package tick_period_monitor_pkg;

  // Width of the free-running half-period counter and of the error counter.
  localparam int CNT_W = 33;
  localparam int ERR_W = 16;
  // One extra bit so EXPECTED + TOLERANCE can never wrap in the window check.
  localparam int WIN_W = CNT_W + 1;

  // Nominal tick generator: 1 Hz square wave seen from a 100 MHz clk.
  localparam logic [31:0] TICK_HALF_NOM = 32'd50000000;
  localparam logic [31:0] TICK_TOL_NOM  = 32'd1000;
  localparam int          TICK_LOCK_NOM = 4;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_MEASURE = 2'd1,
    ST_LOCKED  = 2'd2,
    ST_TIMEOUT = 2'd3
  } state_t;

  // True when hp lies inside [expected - tol, expected + tol]; the lower
  // bound is clamped at zero instead of wrapping when tol exceeds expected.
  function automatic logic in_window(input logic [CNT_W-1:0] hp,
                                     input logic [31:0]      expected,
                                     input logic [31:0]      tol);
    logic [WIN_W-1:0] val;
    logic [WIN_W-1:0] lo;
    logic [WIN_W-1:0] hi;
    val = {1'b0, hp};
    hi  = WIN_W'(expected) + WIN_W'(tol);
    lo  = (expected > tol) ? WIN_W'(expected - tol) : '0;
    return (val >= lo) && (val <= hi);
  endfunction

endpackage

// File: rtl/tick_edge_detect.sv
// Brings the asynchronous tick into the clk domain through two flops, keeps
// one history flop, and emits a registered one-cycle pulse on either edge.
module tick_edge_detect (
  input  logic clk,
  input  logic rst_n,
  input  logic tick,
  output logic edge_pulse
);

  logic sync_meta;
  logic sync_q;
  logic hist_q;

  // Synchronizer, history flop and registered edge pulse.
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge value of its source and the chain shifts exactly one stage.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync_meta  <= 1'b0;
      sync_q     <= 1'b0;
      hist_q     <= 1'b0;
      edge_pulse <= 1'b0;
    end else begin
      sync_meta  <= tick;
      sync_q     <= sync_meta;
      hist_q     <= sync_q;
      edge_pulse <= sync_q ^ hist_q;
    end
  end

endmodule

// File: rtl/tick_period_monitor.sv
// Measures the half-period of an external tick in clk cycles, flags each
// measurement against a tolerance window, declares lock after a run of good
// measurements, and reports a timeout when the tick stops toggling.
module tick_period_monitor
  import tick_period_monitor_pkg::*;
#(
  parameter logic [31:0] EXPECTED_HALF = TICK_HALF_NOM,
  parameter logic [31:0] TOLERANCE     = TICK_TOL_NOM,
  parameter int          LOCK_COUNT    = TICK_LOCK_NOM,
  parameter logic [31:0] TIMEOUT_HALF  = 2 * EXPECTED_HALF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             tick,
  output logic             edge_pulse,
  output logic [CNT_W-1:0] half_period,
  output logic             meas_valid,
  output logic             in_spec,
  output logic             locked,
  output logic             timeout,
  output logic [ERR_W-1:0] err_count
);

  localparam logic [CNT_W-1:0] CNT_MAX     = '1;
  localparam logic [CNT_W-1:0] TMO_LIMIT   = CNT_W'(TIMEOUT_HALF);
  localparam logic [31:0]      LOCK_TARGET = 32'(LOCK_COUNT);
  localparam logic [ERR_W-1:0] ERR_MAX     = '1;

  state_t           state_q;
  state_t           state_d;
  logic [31:0]      run_q;
  logic [31:0]      run_d;
  logic [CNT_W-1:0] cnt_q;
  logic             measuring;
  logic             capture;
  logic             meas_ok;
  logic             tmo_hit;

  tick_edge_detect u_edge (
    .clk        (clk),
    .rst_n      (rst_n),
    .tick       (tick),
    .edge_pulse (edge_pulse)
  );

  // An edge only yields a measurement once a previous edge has started the
  // count; the edge out of IDLE or TIMEOUT merely restarts it. An edge on the
  // same cycle as the timeout threshold is treated as a measurement.
  assign measuring = (state_q == ST_MEASURE) || (state_q == ST_LOCKED);
  assign capture   = edge_pulse && measuring;
  assign meas_ok   = in_window(cnt_q, EXPECTED_HALF, TOLERANCE);
  assign tmo_hit   = measuring && !edge_pulse && (cnt_q >= TMO_LIMIT);

  // Free-running cycle counter: reloads to 1 on each edge, saturates at max.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (edge_pulse) begin
      cnt_q <= CNT_W'(1);
    end else if (cnt_q != CNT_MAX) begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  // State register together with the consecutive in-spec run counter.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      run_q   <= '0;
    end else begin
      state_q <= state_d;
      run_q   <= run_d;
    end
  end

  // Next-state logic and run-counter update.
  // NOTE: every signal assigned here gets a default first, so no path leaves
  // it unassigned and synthesis cannot infer a latch.
  always_comb begin
    state_d = state_q;
    run_d   = run_q;
    unique case (state_q)
      ST_IDLE: begin
        if (edge_pulse) begin
          state_d = ST_MEASURE;
          run_d   = '0;
        end
      end
      ST_MEASURE: begin
        if (capture) begin
          if (!meas_ok) begin
            run_d = '0;
          end else if (run_q + 32'd1 >= LOCK_TARGET) begin
            state_d = ST_LOCKED;
            run_d   = '0;
          end else begin
            run_d = run_q + 32'd1;
          end
        end else if (tmo_hit) begin
          state_d = ST_TIMEOUT;
          run_d   = '0;
        end
      end
      ST_LOCKED: begin
        if (capture && !meas_ok) begin
          state_d = ST_MEASURE;
          run_d   = '0;
        end else if (tmo_hit) begin
          state_d = ST_TIMEOUT;
          run_d   = '0;
        end
      end
      ST_TIMEOUT: begin
        if (edge_pulse) begin
          state_d = ST_MEASURE;
          run_d   = '0;
        end
      end
      default: begin
        state_d = ST_IDLE;
        run_d   = '0;
      end
    endcase
  end

  // Status outputs decoded directly from the current state.
  always_comb begin
    locked  = 1'b0;
    timeout = 1'b0;
    locked  = (state_q == ST_LOCKED);
    timeout = (state_q == ST_TIMEOUT);
  end

  // Measurement capture, validity strobe, window flag and saturating errors.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      half_period <= '0;
      meas_valid  <= 1'b0;
      in_spec     <= 1'b0;
      err_count   <= '0;
    end else begin
      meas_valid <= capture;
      if (capture) begin
        half_period <= cnt_q;
        in_spec     <= meas_ok;
        if (!meas_ok && (err_count != ERR_MAX)) begin
          err_count <= err_count + ERR_W'(1);
        end
      end else if (tmo_hit) begin
        in_spec <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_tick_period_monitor.sv
// Bench for tick_period_monitor with EXPECTED_HALF=10, TOLERANCE=1,
// LOCK_COUNT=4, TIMEOUT_HALF=20. Table rows give the spacing between tick
// toggles plus the expected window flag and lock state; expected measurements
// are queued when a toggle is driven and compared when meas_valid fires.
module tb_tick_period_monitor;
  import tick_period_monitor_pkg::*;

  localparam int CLK_P = 10;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             tick = 1'b0;
  logic             edge_pulse;
  logic [CNT_W-1:0] half_period;
  logic             meas_valid;
  logic             in_spec;
  logic             locked;
  logic             timeout;
  logic [ERR_W-1:0] err_count;

  always #(CLK_P / 2) clk = ~clk;

  tick_period_monitor #(
    .EXPECTED_HALF (32'd10),
    .TOLERANCE     (32'd1),
    .LOCK_COUNT    (4),
    .TIMEOUT_HALF  (32'd20)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .tick        (tick),
    .edge_pulse  (edge_pulse),
    .half_period (half_period),
    .meas_valid  (meas_valid),
    .in_spec     (in_spec),
    .locked      (locked),
    .timeout     (timeout),
    .err_count   (err_count)
  );

  typedef struct {
    int   half;
    logic in_spec;
    logic locked;
  } vec_t;

  typedef struct {
    logic [CNT_W-1:0] hp;
    logic             in_spec;
    logic             locked;
    logic [ERR_W-1:0] err;
  } exp_t;

  exp_t  sb_q[$];
  vec_t  vecs[22];
  int    n_tests = 0;
  int    n_fail  = 0;
  int    exp_err = 0;
  bit    mon_en  = 1'b1;
  time   last_toggle = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_edge_pulse"}, 64'(edge_pulse), 64'd0);
    check({tag, "_half_period"}, 64'(half_period), 64'd0);
    check({tag, "_meas_valid"}, 64'(meas_valid), 64'd0);
    check({tag, "_in_spec"}, 64'(in_spec), 64'd0);
    check({tag, "_locked"}, 64'(locked), 64'd0);
    check({tag, "_timeout"}, 64'(timeout), 64'd0);
    check({tag, "_err_count"}, 64'(err_count), 64'd0);
  endtask

  // Toggle tick on the negedge that lies n clk cycles after the last toggle
  // (immediately if that point has already passed).
  task automatic toggle_after(input int n);
    while (($time - last_toggle) < time'(n * CLK_P)) @(negedge clk);
    tick = ~tick;
    last_toggle = $time;
  endtask

  task automatic run_row(input vec_t v);
    exp_t e;
    toggle_after(v.half);
    if (!v.in_spec) exp_err++;
    e.hp      = CNT_W'(v.half);
    e.in_spec = v.in_spec;
    e.locked  = v.locked;
    e.err     = ERR_W'(exp_err);
    sb_q.push_back(e);
  endtask

  task automatic drain(input string tag);
    for (int i = 0; i < 60 && sb_q.size() != 0; i++) @(negedge clk);
    check({tag, "_sb_empty"}, 64'(sb_q.size()), 64'd0);
    sb_q.delete();
  endtask

  // Scoreboard monitor: every meas_valid must match the oldest queued entry.
  always @(negedge clk) begin
    if (mon_en && meas_valid) begin
      if (sb_q.size() == 0) begin
        check("meas_valid_unexpected", 64'(meas_valid), 64'd0);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        check("meas_half_period", 64'(half_period), 64'(e.hp));
        check("meas_in_spec", 64'(in_spec), 64'(e.in_spec));
        check("meas_locked", 64'(locked), 64'(e.locked));
        check("meas_err_count", 64'(err_count), 64'(e.err));
        check("meas_timeout", 64'(timeout), 64'd0);
      end
    end
  end

  initial begin
    int n;
    vecs[0]  = '{10, 1'b1, 1'b0};
    vecs[1]  = '{10, 1'b1, 1'b0};
    vecs[2]  = '{10, 1'b1, 1'b0};
    vecs[3]  = '{10, 1'b1, 1'b1};
    vecs[4]  = '{10, 1'b1, 1'b1};
    vecs[5]  = '{13, 1'b0, 1'b0};
    vecs[6]  = '{10, 1'b1, 1'b0};
    vecs[7]  = '{10, 1'b1, 1'b0};
    vecs[8]  = '{10, 1'b1, 1'b0};
    vecs[9]  = '{10, 1'b1, 1'b1};
    vecs[10] = '{9,  1'b1, 1'b1};
    vecs[11] = '{11, 1'b1, 1'b1};
    vecs[12] = '{8,  1'b0, 1'b0};
    vecs[13] = '{12, 1'b0, 1'b0};
    vecs[14] = '{9,  1'b1, 1'b0};
    vecs[15] = '{11, 1'b1, 1'b0};
    vecs[16] = '{20, 1'b0, 1'b0};
    vecs[17] = '{10, 1'b1, 1'b0};
    vecs[18] = '{10, 1'b1, 1'b0};
    vecs[19] = '{10, 1'b1, 1'b0};
    vecs[20] = '{10, 1'b1, 1'b1};
    vecs[21] = '{11, 1'b1, 1'b1};

    // Reset state, then idle past the timeout threshold without any edge.
    repeat (3) @(negedge clk);
    check_zero("reset");
    rst_n = 1'b1;
    repeat (30) @(negedge clk);
    check("idle_no_timeout", 64'(timeout), 64'd0);
    check("idle_not_locked", 64'(locked), 64'd0);

    // First edge: pulse exactly three clk edges after the transition, no
    // measurement captured.
    toggle_after(1);
    repeat (2) @(negedge clk);
    check("edge_lat_before", 64'(edge_pulse), 64'd0);
    @(negedge clk);
    check("edge_lat_at3", 64'(edge_pulse), 64'd1);
    @(negedge clk);
    check("edge_lat_after", 64'(edge_pulse), 64'd0);

    // Table of half-periods: lock, violation, relock, window edges, tie case.
    foreach (vecs[i]) run_row(vecs[i]);

    // Tick stops while locked: timeout 24 cycles after the last transition,
    // i.e. 20 cycles after the last measurement.
    n = 0;
    for (int i = 1; i <= 60; i++) begin
      @(negedge clk);
      n = i;
      if (timeout) break;
    end
    check("timeout_latency", 64'(n), 64'd24);
    check("timeout_locked", 64'(locked), 64'd0);
    check("timeout_in_spec", 64'(in_spec), 64'd0);
    drain("table");

    // Recovery edge clears timeout without a measurement; then relock.
    toggle_after(5);
    repeat (6) @(negedge clk);
    check("recover_timeout", 64'(timeout), 64'd0);
    check("recover_locked", 64'(locked), 64'd0);
    for (int i = 0; i < 4; i++) run_row('{10, 1'b1, (i == 3)});
    drain("relock");

    // One-cycle reset in the middle of a measurement.
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    check_zero("midreset");
    rst_n = 1'b1;
    exp_err = 0;
    toggle_after(7);
    run_row('{10, 1'b1, 1'b0});
    drain("postreset");

    // Error counter saturation: toggle every cycle so each edge is a bad
    // one-cycle measurement (the first edge only starts measuring).
    mon_en = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 65535; i++) begin
      @(negedge clk);
      tick = ~tick;
    end
    repeat (6) @(negedge clk);
    check("err_count_fffe", 64'(err_count), 64'hFFFE);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      tick = ~tick;
    end
    repeat (6) @(negedge clk);
    check("err_count_sat", 64'(err_count), 64'hFFFF);
    check("sat_in_spec", 64'(in_spec), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
